// File: rtl/stream_delay_pkg.sv
// Shared types and helpers for the stream delay pipe and its bench.
package stream_delay_pkg;

  // Where a beat's delay comes from.
  typedef enum logic [1:0] {
    DelayFixed,
    DelayRandom,
    DelayPort
  } delay_mode_e;

  // Fibonacci taps on bits 0,2,3,5 (x^16 + x^14 + x^13 + x^11), shifting right.
  localparam logic [15:0] LfsrTaps = 16'h002D;

  // Fewest cycles between acceptance and the first cycle the beat can be
  // presented downstream for a given delay value.
  function automatic int unsigned min_latency(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/lfsr_16bit.sv
// 16-bit maximal-length Fibonacci LFSR that steps only when enabled.
module lfsr_16bit
  import stream_delay_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  // Advance one step per enable; the new bit enters at the top.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else if (en_i) begin
      lfsr_q <= {^(lfsr_q & LfsrTaps), lfsr_q[15:1]};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/stream_delay_pipe.sv
// stream_delay_pipe: valid/ready delay line holding up to Depth beats in flight.
// Each beat is held at least max(d,1) cycles after acceptance, order preserved.
// Optional SVA checkers: define STREAM_DELAY_PIPE_ASSERT_EN.
module stream_delay_pipe
  import stream_delay_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 4,
  parameter int unsigned DelayWidth = 8,
  parameter delay_mode_e Mode       = DelayFixed,
  parameter int unsigned FixedDelay = 1,
  parameter logic [15:0] Seed       = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DelayWidth-1:0]        delay_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DataWidth-1:0]         data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(Depth+1)-1:0]   inflight_o
);

  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

  logic [DataWidth-1:0]  data_q [Depth];
  logic [DelayWidth-1:0] cnt_q  [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q;
  logic [DelayWidth-1:0] delay_d, load_cnt;
  logic                  push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle never frees space for this cycle's push.
  assign ready_o = !rst_i && (count_q != FullCount);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Delay source selected at elaboration.
  generate
    if (Mode == DelayRandom) begin : g_lfsr
      logic [15:0] lfsr;
      logic        unused_sink;
      lfsr_16bit #(.Seed(Seed)) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (push),
        .lfsr_o (lfsr)
      );
      // Zero-extends when DelayWidth > 16, truncates otherwise.
      assign delay_d     = DelayWidth'(lfsr);
      assign unused_sink = ^{lfsr, delay_i};
    end else if (Mode == DelayPort) begin : g_port
      assign delay_d = delay_i;
    end else begin : g_fixed
      logic unused_sink;
      assign delay_d     = DelayWidth'(FixedDelay);
      assign unused_sink = ^delay_i;
    end
  endgenerate

  // Counter value stored with a new beat; d and d-1 both count as one cycle.
  always_comb begin
    load_cnt = (delay_d == '0) ? '0 : delay_d - 1'b1;
  end

  // Occupancy and ring pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Payload storage.
  // NOTE: the payload array is deliberately left out of reset; occupancy and
  // the output gating below make stale contents invisible.
  always_ff @(posedge clk_i) begin
    if (push) data_q[wr_ptr_q] <= data_i;
  end

  // Per-entry countdown; keeps running while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (push && (wr_ptr_q == PtrWidth'(i))) cnt_q[i] <= load_cnt;
        else if (cnt_q[i] != '0)                cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Head presentation, forced quiet during reset.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    valid_o    = 1'b0;
    data_o     = '0;
    inflight_o = '0;
    if (!rst_i) begin
      inflight_o = count_q;
      if (count_q != '0) begin
        data_o  = data_q[rd_ptr_q];
        valid_o = (cnt_q[rd_ptr_q] == '0);
      end
    end
  end

`ifdef STREAM_DELAY_PIPE_ASSERT_EN
  // Upstream must hold valid and payload until accepted.
  a_in_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i)))
    else $error("stream_delay_pipe: valid_i/data_i changed before accept");

  // Downstream sees valid and payload held until the pop.
  a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)))
    else $error("stream_delay_pipe: valid_o/data_o changed before pop");

  // Occupancy never exceeds the buffer.
  a_inflight_max : assert property (@(posedge clk_i) disable iff (rst_i)
    inflight_o <= FullCount);

  // Parameter legality.
  if (DataWidth < 1 || Depth < 1 || DelayWidth < 1) begin : g_bad_size
    $fatal(1, "stream_delay_pipe: DataWidth, Depth and DelayWidth must be >= 1");
  end
  if (Mode == DelayFixed && DelayWidth < 32 && (FixedDelay >> DelayWidth) != 0) begin : g_bad_fixed
    $fatal(1, "stream_delay_pipe: FixedDelay does not fit in DelayWidth");
  end
  if (Mode == DelayRandom && Seed == 16'h0000) begin : g_bad_seed
    $fatal(1, "stream_delay_pipe: Seed must be nonzero");
  end
`else
  // Checkers not compiled; datapath and timing are identical.
`endif

endmodule

// File: tb/tb_stream_delay_pipe.sv
// Bench for stream_delay_pipe: four instances (fixed, port, random, depth-1)
// checked every cycle against a timestamp scoreboard.
module tb_stream_delay_pipe;
  import stream_delay_pkg::*;

  localparam int NInst = 4;
  localparam int Depths [NInst] = '{4, 4, 3, 1};
  localparam logic [15:0] SeedVal = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din  [NInst];
  logic [7:0] dout [NInst];
  logic [7:0] dly  [NInst];
  logic       vin  [NInst];
  logic       rdy  [NInst];
  logic       vout [NInst];
  logic       rin  [NInst];
  logic [2:0] inf0, inf1;
  logic [1:0] inf2;
  logic [0:0] inf3;

  stream_delay_pipe #(.DataWidth(8), .Depth(4), .DelayWidth(8), .Mode(DelayFixed),
                      .FixedDelay(3)) u_fixed (
    .clk_i(clk), .rst_i(rst), .delay_i(dly[0]), .data_i(din[0]), .valid_i(vin[0]),
    .ready_o(rdy[0]), .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]),
    .inflight_o(inf0));

  stream_delay_pipe #(.DataWidth(8), .Depth(4), .DelayWidth(8), .Mode(DelayPort)) u_port (
    .clk_i(clk), .rst_i(rst), .delay_i(dly[1]), .data_i(din[1]), .valid_i(vin[1]),
    .ready_o(rdy[1]), .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]),
    .inflight_o(inf1));

  stream_delay_pipe #(.DataWidth(8), .Depth(3), .DelayWidth(3), .Mode(DelayRandom),
                      .Seed(SeedVal)) u_rand (
    .clk_i(clk), .rst_i(rst), .delay_i(dly[2][2:0]), .data_i(din[2]), .valid_i(vin[2]),
    .ready_o(rdy[2]), .data_o(dout[2]), .valid_o(vout[2]), .ready_i(rin[2]),
    .inflight_o(inf2));

  stream_delay_pipe #(.DataWidth(8), .Depth(1), .DelayWidth(8), .Mode(DelayPort)) u_single (
    .clk_i(clk), .rst_i(rst), .delay_i(dly[3]), .data_i(din[3]), .valid_i(vin[3]),
    .ready_o(rdy[3]), .data_o(dout[3]), .valid_o(vout[3]), .ready_i(rin[3]),
    .inflight_o(inf3));

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         acc;   // edge number at which the beat was accepted
    int         ml;    // min_latency of its delay
  } beat_t;

  beat_t       sbq[$];
  int          last_pop [NInst];
  int          n_acc    [NInst];
  int          n_pop    [NInst];
  bit          acc_ev   [NInst];
  int          src_mode [NInst];   // 0 off, 1 random source, 2 stop after current beat
  int          vin_pct  [NInst];
  bit          rnd_rdy  [NInst];
  int          cyc;
  logic [15:0] lfsr_m;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int infl(input int k);
    case (k)
      0:       return int'(inf0);
      1:       return int'(inf1);
      2:       return int'(inf2);
      default: return int'(inf3);
    endcase
  endfunction

  function automatic int head_idx(input int k);
    for (int j = 0; j < sbq.size(); j++) if (sbq[j].inst == k) return j;
    return -1;
  endfunction

  function automatic int q_size(input int k);
    int n = 0;
    for (int j = 0; j < sbq.size(); j++) if (sbq[j].inst == k) n++;
    return n;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // One clock: compare outputs mid-cycle, cross the edge, update the model.
  task automatic tick();
    bit   acc [NInst];
    bit   pop [NInst];
    bit   rst_s;
    int   h, elig, d;
    bit   mv, mr;
    logic [7:0] md;
    #1;
    rst_s = rst;
    for (int k = 0; k < NInst; k++) begin
      acc[k] = 0;
      pop[k] = 0;
      if (rst_s) begin
        check("rst_valid",    vout[k],  0);
        check("rst_ready",    rdy[k],   0);
        check("rst_data",     dout[k],  0);
        check("rst_inflight", infl(k),  0);
      end else begin
        h  = head_idx(k);
        mv = 0;
        md = 8'h00;
        if (h >= 0) begin
          elig = sbq[h].acc + sbq[h].ml;
          if (last_pop[k] + 1 > elig) elig = last_pop[k] + 1;
          mv = (cyc + 1 >= elig);
          md = sbq[h].data;
        end
        mr = (q_size(k) != Depths[k]);
        check("valid_o",    vout[k], mv);
        check("data_o",     dout[k], md);
        check("ready_o",    rdy[k],  mr);
        check("inflight_o", infl(k), q_size(k));
        acc[k] = vin[k] && mr;
        pop[k] = mv && rin[k];
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < NInst; k++) begin
      acc_ev[k] = acc[k];
      if (rst_s) begin
        for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].inst == k) sbq.delete(j);
        last_pop[k] = 0;
        if (k == 2) lfsr_m = SeedVal;
      end else begin
        if (pop[k]) begin
          sbq.delete(head_idx(k));
          last_pop[k] = cyc;
          n_pop[k]++;
        end
        if (acc[k]) begin
          if (k == 0)      d = 3;
          else if (k == 2) d = int'(lfsr_m[2:0]);
          else             d = int'(dly[k]);
          sbq.push_back('{k, din[k], cyc, int'(min_latency(d))});
          if (k == 2) lfsr_m = lfsr_step(lfsr_m);
          n_acc[k]++;
        end
        if (src_mode[k] == 2) begin
          if (acc[k] || !vin[k]) begin
            vin[k]      = 1'b0;
            src_mode[k] = 0;
          end
        end else if (src_mode[k] == 1) begin
          if (acc[k] || !vin[k]) begin
            vin[k] = ($urandom_range(0, 99) < vin_pct[k]);
            din[k] = 8'($urandom);
          end
        end
        if (rnd_rdy[k]) rin[k] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Offer one beat and hold it until accepted; returns the accept edge.
  task automatic send(input int k, input logic [7:0] data, input logic [7:0] d, output int at);
    vin[k] = 1'b1;
    din[k] = data;
    dly[k] = d;
    at = -1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (acc_ev[k]) begin
        at = cyc;
        break;
      end
    end
    vin[k] = 1'b0;
    check("send_accepted", at >= 0, 1);
  endtask

  task automatic drain(input int k);
    for (int n = 0; n < 300; n++) begin
      if (q_size(k) == 0 && !vin[k]) break;
      tick();
    end
    check("drain_empty", q_size(k), 0);
  endtask

  initial begin
    int a1, a2, p0, n0;
    int exp_lat [4] = '{1, 1, 1, 4};
    rst    = 1'b1;
    cyc    = 0;
    lfsr_m = SeedVal;
    for (int k = 0; k < NInst; k++) begin
      din[k] = '0; dly[k] = '0; vin[k] = 1'b0; rin[k] = 1'b0;
      src_mode[k] = 0; vin_pct[k] = 0; rnd_rdy[k] = 0;
      last_pop[k] = 0; n_acc[k] = 0; n_pop[k] = 0; acc_ev[k] = 0;
    end
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // T1: fixed delay 3, single beat
    rin[0] = 1'b1;
    send(0, 8'hA5, 8'h00, a1);
    drain(0);
    check("t1_latency", last_pop[0] - a1, 3);

    // T2: stalled sink fills the buffer, then drains in order
    rin[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i), 8'h00, a1);
    vin[0] = 1'b1;
    din[0] = 8'h14;
    repeat (2) tick();
    check("t2_ready_full", rdy[0], 0);
    check("t2_inflight",   infl(0), 4);
    p0 = n_pop[0];
    rin[0] = 1'b1;
    send(0, 8'h14, 8'h00, a1);
    send(0, 8'h15, 8'h00, a1);
    drain(0);
    check("t2_pops", n_pop[0] - p0, 6);

    // T3: long delay blocks a short one behind it
    rin[1] = 1'b1;
    send(1, 8'hB1, 8'd5, a1);
    send(1, 8'hB2, 8'd1, a2);
    check("t3_back_to_back", a2 - a1, 1);
    drain(1);
    check("t3_second_pop", last_pop[1] - a1, 6);

    // T4: delays 0 and 1 both give one cycle; depth 1 runs at half rate
    send(1, 8'hC0, 8'd0, a1);
    drain(1);
    check("t4_lat_d0", last_pop[1] - a1, 1);
    send(1, 8'hC1, 8'd1, a1);
    drain(1);
    check("t4_lat_d1", last_pop[1] - a1, 1);
    rin[3] = 1'b1; dly[3] = 8'd1; vin_pct[3] = 100;
    vin[3] = 1'b1; din[3] = 8'h30; src_mode[3] = 1;
    n0 = n_acc[3];
    repeat (20) tick();
    check("t4_throughput", n_acc[3] - n0, 10);
    src_mode[3] = 2;
    drain(3);

    // T5: random delays, random sink stalls, 1000 beats
    vin_pct[2] = 75; rnd_rdy[2] = 1; src_mode[2] = 1;
    for (int n = 0; n < 20000 && n_acc[2] < 1000; n++) tick();
    check("t5_beats_sent", n_acc[2] >= 1000, 1);
    src_mode[2] = 2; rnd_rdy[2] = 0; rin[2] = 1'b1;
    drain(2);
    check("t5_no_loss", n_pop[2], n_acc[2]);

    // T6: reset with three beats in flight
    rin[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h40 + i), 8'h00, a1);
    check("t6_pre_inflight", infl(0), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_inflight", infl(0), 0);
    check("t6_valid",    vout[0], 0);
    check("t6_ready",    rdy[0], 1);
    rin[0] = 1'b1;
    send(0, 8'hD0, 8'h00, a1);
    drain(0);
    check("t6_fixed_lat", last_pop[0] - a1, 3);
    for (int i = 0; i < 4; i++) begin
      send(2, 8'(8'hE0 + i), 8'h00, a1);
      drain(2);
      check("t6_lfsr_lat", last_pop[2] - a1, exp_lat[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
